receptor_jogada: RTL and testbench
==================================

Name: receptor_jogada

Overview:
- Serial front end that delivers player moves from the ESP board-sensor link to the game control unit.
- Receives 8N1 UART bytes, assembles a 4-byte move frame, checks it, then presents the move with a level `temJogada` flag.
- Holds the move until the control unit acknowledges it with `registraR`.
- Forms the producer end of the `temJogada`/`registraR` handshake.

Parameters:
- DIV, 434, clock cycles per UART bit (50 MHz / 115200); must be ≥ 4.
- TIMEOUT, 20, bit periods allowed between consecutive bytes of one frame.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx  in  1  UART line from ESP, idle high, asynchronous to clock
- registraR  in  1  acknowledge from control unit; consumes held move
- limpaErro  in  1  synchronous clear of erro_quadro
- temJogada  out  1  valid move held
- origem  out  6  source square 0..63
- destino  out  6  destination square 0..63
- erro_quadro  out  1  sticky error flag
- db_estado  out  4  frame FSM state, for debug display

Behaviour:
- Reset values: temJogada=0, origem=0, destino=0, erro_quadro=0, db_estado=0. Internal state: byte receiver idle, frame FSM in ESPERA_CAB, sync flops=1.
- reset is asynchronous; asserting it mid-byte or mid-frame discards all partial data immediately.
- rx passes through a 2-flop synchronizer. All timing below is measured on the synchronized signal.
- Byte receiver:
  - A falling edge while idle starts a byte.
  - After DIV/2 cycles the line is re-checked. If it is high, this is a glitch: return to idle with no error.
  - The 8 data bits are then sampled every DIV cycles, LSB first.
  - The stop bit is sampled DIV cycles after the last data bit. If the stop bit is 0: framing error, set erro_quadro, discard the byte, and the frame FSM returns to ESPERA_CAB.
  - On a good stop bit: a one-cycle internal byte strobe, and the receiver returns to idle immediately. Back-to-back bytes must be accepted.
- Frame format: 0xA5, O, D, C.
  - O and D are squares; bits 7:6 must be 00.
  - C must equal O ^ D ^ 0x5A.
- Frame FSM (db_estado value):
  - ESPERA_CAB (0): a byte equal to 0xA5 moves to ORIGEM. Any other byte is ignored silently.
  - ORIGEM (1): store O and move to DESTINO. If O[7:6]≠0, set erro_quadro and return to ESPERA_CAB.
  - DESTINO (2): store D and move to CHECK. If D[7:6]≠0, same error handling as ORIGEM.
  - CHECK (3): if C matches, move to ENTREGA. Otherwise set erro_quadro and return to ESPERA_CAB.
  - ENTREGA (4): lasts one cycle, then returns to ESPERA_CAB.
    - If temJogada=0, or registraR=1 on this same edge: load origem/destino and set temJogada=1.
    - Otherwise (overrun): discard the frame, set erro_quadro, leave the held move untouched.
- Inter-byte timeout: in ORIGEM, DESTINO and CHECK, a cycle counter restarts on each byte strobe. If it reaches TIMEOUT*DIV with no byte in progress, set erro_quadro and return to ESPERA_CAB.
- Latency: temJogada rises 2 clock edges after the stop-bit sample of byte C (strobe edge, then ENTREGA edge).
- Handshake:
  - temJogada stays high and origem/destino stay stable until an edge where registraR=1. temJogada is 0 after that edge.
  - registraR while temJogada=0 is ignored.
  - registraR held high for multiple cycles consumes only the held move. A move loaded on the same edge survives, per the ENTREGA rule.
- erro_quadro:
  - Set by any error above.
  - Cleared only by reset, or by limpaErro on an edge with no simultaneous error (set wins).
  - Errors never affect temJogada or the held move.

Test Plan:
- Reset then frame A5 0C 1C 4A (DIV=8): temJogada=1 with origem=12, destino=28, 2 cycles after byte-3 stop sample; registraR pulse → temJogada=0 next edge, outputs hold 12/28.
- Bad checksum A5 0C 1C 00 → erro_quadro=1, temJogada stays 0, FSM back in 0; limpaErro pulse → erro_quadro=0.
- Noise bytes 33 FF then valid frame A5 00 3F 65 → noise ignored with no error; move 0→63 delivered.
- Two frames back-to-back with no registraR: first delivered; second causes erro_quadro=1, held move unchanged. Repeat with registraR on the second frame's ENTREGA edge → second move loaded, temJogada stays 1.
- Stop bit forced to 0 on the O byte → erro_quadro=1, FSM back in 0. A 2-cycle low glitch on idle rx → nothing received, no error.
- A5 then silence longer than TIMEOUT*DIV → erro_quadro=1, FSM back in 0. Async reset asserted mid-byte → all outputs return to 0 immediately.

Source files
------------

// File: rtl/receptor_jogada.sv
// UART 8N1 move receiver: frame A5,O,D,C -> validated move held on temJogada.
// Ports: clock/reset, rx, registraR (ack), limpaErro; temJogada, origem, destino, erro_quadro, db_estado.
module receptor_jogada #(
  parameter int DIV     = 434,
  parameter int TIMEOUT = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  input  logic       registraR,
  input  logic       limpaErro,
  output logic       temJogada,
  output logic [5:0] origem,
  output logic [5:0] destino,
  output logic       erro_quadro,
  output logic [3:0] db_estado
);

  localparam int CW   = $clog2(DIV);
  localparam int TMAX = TIMEOUT * DIV;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_st_t;

  typedef enum logic [2:0] {
    ESPERA_CAB = 3'd0,
    ORIGEM     = 3'd1,
    DESTINO    = 3'd2,
    CHECK      = 3'd3,
    ENTREGA    = 3'd4
  } fr_st_t;

  // synchronizer plus one extra flop for falling-edge detection
  logic rx_s1, rx_s2, rx_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // byte receiver
  rx_st_t     r_q, r_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bitn, bitn_n;
  logic [7:0] sh, sh_n;
  logic       stb, stb_n;
  logic       ferr, ferr_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q  <= R_IDLE;
      cnt  <= '0;
      bitn <= '0;
      sh   <= '0;
      stb  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      r_q  <= r_n;
      cnt  <= cnt_n;
      bitn <= bitn_n;
      sh   <= sh_n;
      stb  <= stb_n;
      ferr <= ferr_n;
    end
  end

  always_comb begin
    r_n    = r_q;
    cnt_n  = cnt + 1'b1;
    bitn_n = bitn;
    sh_n   = sh;
    stb_n  = 1'b0;
    ferr_n = 1'b0;
    unique case (r_q)
      R_IDLE: begin
        cnt_n = '0;
        if (rx_d && !rx_s2) r_n = R_START;
      end
      R_START: begin
        // mid-start re-check; high line means a glitch
        if (cnt == CW'(DIV / 2 - 1)) begin
          cnt_n  = '0;
          bitn_n = '0;
          r_n    = rx_s2 ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt == CW'(DIV - 1)) begin
          cnt_n  = '0;
          sh_n   = {rx_s2, sh[7:1]};
          bitn_n = bitn + 3'd1;
          if (bitn == 3'd7) r_n = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt == CW'(DIV - 1)) begin
          r_n    = R_IDLE;
          stb_n  = rx_s2;
          ferr_n = !rx_s2;
        end
      end
      default: r_n = R_IDLE;
    endcase
  end

  // frame FSM
  fr_st_t        f_q, f_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [5:0]    o_q, o_n, d_q, d_n;
  logic [5:0]    org_n, dst_n;
  logic          tj_n, erro_n, err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      f_q         <= ESPERA_CAB;
      tcnt        <= '0;
      o_q         <= '0;
      d_q         <= '0;
      temJogada   <= 1'b0;
      origem      <= '0;
      destino     <= '0;
      erro_quadro <= 1'b0;
    end else begin
      f_q         <= f_n;
      tcnt        <= tcnt_n;
      o_q         <= o_n;
      d_q         <= d_n;
      temJogada   <= tj_n;
      origem      <= org_n;
      destino     <= dst_n;
      erro_quadro <= erro_n;
    end
  end

  always_comb begin
    f_n    = f_q;
    tcnt_n = '0;
    o_n    = o_q;
    d_n    = d_q;
    tj_n   = temJogada;
    org_n  = origem;
    dst_n  = destino;
    err    = 1'b0;
    if (registraR) tj_n = 1'b0;
    unique case (f_q)
      ESPERA_CAB: begin
        if (stb && sh == 8'hA5) f_n = ORIGEM;
      end
      ORIGEM: begin
        if (stb) begin
          if (sh[7:6] != 2'b00) begin
            err = 1'b1;
            f_n = ESPERA_CAB;
          end else begin
            o_n = sh[5:0];
            f_n = DESTINO;
          end
        end
      end
      DESTINO: begin
        if (stb) begin
          if (sh[7:6] != 2'b00) begin
            err = 1'b1;
            f_n = ESPERA_CAB;
          end else begin
            d_n = sh[5:0];
            f_n = CHECK;
          end
        end
      end
      CHECK: begin
        if (stb) begin
          if (sh == ({2'b00, o_q ^ d_q} ^ 8'h5A)) begin
            f_n = ENTREGA;
          end else begin
            err = 1'b1;
            f_n = ESPERA_CAB;
          end
        end
      end
      ENTREGA: begin
        f_n = ESPERA_CAB;
        // an ack on this edge frees the slot for the new move
        if (!temJogada || registraR) begin
          tj_n  = 1'b1;
          org_n = o_q;
          dst_n = d_q;
        end else begin
          err = 1'b1;
        end
      end
      default: f_n = ESPERA_CAB;
    endcase
    // inter-byte timeout, saturating counter
    if (f_q == ORIGEM || f_q == DESTINO || f_q == CHECK) begin
      if (stb) begin
        tcnt_n = '0;
      end else if (tcnt == TW'(TMAX)) begin
        tcnt_n = tcnt;
        if (r_q == R_IDLE) begin
          err = 1'b1;
          f_n = ESPERA_CAB;
        end
      end else begin
        tcnt_n = tcnt + 1'b1;
      end
    end
    if (ferr) begin
      err = 1'b1;
      f_n = ESPERA_CAB;
    end
    if (err)            erro_n = 1'b1;
    else if (limpaErro) erro_n = 1'b0;
    else                erro_n = erro_quadro;
  end

  assign db_estado = {1'b0, f_q};

endmodule

// File: tb/tb_receptor_jogada.sv
// Directed bench for receptor_jogada with DIV=8, TIMEOUT=20.
// Drives UART bytes on falling clock edges and checks outputs there.
module tb_receptor_jogada;

  localparam int DIV = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic       registraR;
  logic       limpaErro;
  logic       temJogada;
  logic [5:0] origem;
  logic [5:0] destino;
  logic       erro_quadro;
  logic [3:0] db_estado;

  int total = 0;
  int bad   = 0;

  receptor_jogada #(.DIV(DIV), .TIMEOUT(20)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .registraR  (registraR),
    .limpaErro  (limpaErro),
    .temJogada  (temJogada),
    .origem     (origem),
    .destino    (destino),
    .erro_quadro(erro_quadro),
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    repeat (DIV) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clock);
    end
    rx = stop;
    repeat (DIV) @(negedge clock);
  endtask

  task automatic pulse_ack();
    registraR = 1'b1;
    @(negedge clock);
    registraR = 1'b0;
  endtask

  task automatic pulse_clr();
    limpaErro = 1'b1;
    @(negedge clock);
    limpaErro = 1'b0;
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    rx        = 1'b1;
    registraR = 1'b0;
    limpaErro = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_tj", temJogada, 0);
    chk("rst_org", origem, 0);
    chk("rst_dst", destino, 0);
    chk("rst_err", erro_quadro, 0);
    chk("rst_st", db_estado, 0);

    // frame A5 0C 1C 4A, latency two edges after stop sample
    send_byte(8'hA5);
    chk("f1_st_org", db_estado, 1);
    send_byte(8'h0C);
    send_byte(8'h1C);
    send_byte(8'h4A);
    chk("f1_st_ent", db_estado, 4);
    chk("f1_tj_early", temJogada, 0);
    @(negedge clock);
    chk("f1_tj", temJogada, 1);
    chk("f1_org", origem, 12);
    chk("f1_dst", destino, 28);
    chk("f1_err", erro_quadro, 0);
    chk("f1_st_back", db_estado, 0);
    pulse_ack();
    chk("ack_tj", temJogada, 0);
    chk("ack_org", origem, 12);
    chk("ack_dst", destino, 28);
    repeat (3) @(negedge clock);
    chk("ack_hold", temJogada, 0);

    // bad checksum
    send_byte(8'hA5);
    send_byte(8'h0C);
    send_byte(8'h1C);
    send_byte(8'h00);
    chk("cks_err", erro_quadro, 1);
    chk("cks_tj", temJogada, 0);
    chk("cks_st", db_estado, 0);
    pulse_clr();
    chk("clr_err", erro_quadro, 0);

    // noise then move 0 -> 63
    send_byte(8'h33);
    send_byte(8'hFF);
    chk("noise_err", erro_quadro, 0);
    chk("noise_st", db_estado, 0);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h3F);
    send_byte(8'h65);
    @(negedge clock);
    chk("f2_tj", temJogada, 1);
    chk("f2_org", origem, 0);
    chk("f2_dst", destino, 63);
    chk("f2_err", erro_quadro, 0);
    pulse_ack();

    // overrun: two frames without ack
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h0A);
    send_byte(8'h55);
    @(negedge clock);
    chk("ov1_tj", temJogada, 1);
    chk("ov1_org", origem, 5);
    chk("ov1_dst", destino, 10);
    send_byte(8'hA5);
    send_byte(8'h07);
    send_byte(8'h09);
    send_byte(8'h54);
    @(negedge clock);
    chk("ov2_err", erro_quadro, 1);
    chk("ov2_tj", temJogada, 1);
    chk("ov2_org", origem, 5);
    chk("ov2_dst", destino, 10);
    pulse_clr();
    chk("ov_clr", erro_quadro, 0);

    // ack on the ENTREGA edge lets the new move in
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h59);
    chk("same_st", db_estado, 4);
    registraR = 1'b1;
    @(negedge clock);
    registraR = 1'b0;
    chk("same_tj", temJogada, 1);
    chk("same_org", origem, 1);
    chk("same_dst", destino, 2);
    chk("same_err", erro_quadro, 0);

    // framing error on O byte
    send_byte(8'hA5);
    send_byte(8'h0C, 1'b0);
    chk("fe_err", erro_quadro, 1);
    chk("fe_st", db_estado, 0);
    chk("fe_tj", temJogada, 1);
    chk("fe_org", origem, 1);
    rx = 1'b1;
    repeat (4) @(negedge clock);
    pulse_clr();
    chk("fe_clr", erro_quadro, 0);

    // 2-cycle glitch
    rx = 1'b0;
    repeat (2) @(negedge clock);
    rx = 1'b1;
    repeat (30) @(negedge clock);
    chk("gl_err", erro_quadro, 0);
    chk("gl_st", db_estado, 0);

    // timeout after header
    send_byte(8'hA5);
    chk("to_st1", db_estado, 1);
    repeat (100) @(negedge clock);
    chk("to_early_err", erro_quadro, 0);
    chk("to_early_st", db_estado, 1);
    n = 0;
    while (!erro_quadro && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("to_err", erro_quadro, 1);
    chk("to_st", db_estado, 0);
    chk("to_tj", temJogada, 1);

    // async reset mid-byte
    rx = 1'b0;
    repeat (20) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("ar_tj", temJogada, 0);
    chk("ar_org", origem, 0);
    chk("ar_dst", destino, 0);
    chk("ar_err", erro_quadro, 0);
    chk("ar_st", db_estado, 0);
    rx = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    chk("ar_after_st", db_estado, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
